// File: rtl/seg7_decode_capture.sv
// seg7_decode_capture: samples a multiplexed active-low seven-segment bus, debounces
// each digit, decodes it back to hex and hands complete frames off via valid/ack.
`timescale 1ns/1ps

module seg7_digit_track #(
   parameter int STABLE_COUNT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [6:0] seg,
   output logic       commit
);
   logic [6:0] cand;
   logic [3:0] cnt;
   logic       same;

   assign same = (seg == cand);
   // Fires once, on the sample that brings the run of identical samples to STABLE_COUNT.
   assign commit = en && (same ? (cnt == 4'(STABLE_COUNT - 1)) : (STABLE_COUNT == 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand <= 7'h7F;
         cnt  <= '0;
      end else if (en) begin
         if (!same) begin
            cand <= seg;
            cnt  <= 4'd1;
         end else if (cnt != 4'(STABLE_COUNT)) begin
            cnt <= cnt + 4'd1;
         end
      end
   end
endmodule

module seg7_decode_capture #(
   parameter int NUM_DIGITS   = 8,
   parameter int STABLE_COUNT = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_in,
   input  logic [2:0]              seg_idx,
   input  logic                    seg_valid,
   output logic [4*NUM_DIGITS-1:0] hex_out,
   output logic [NUM_DIGITS-1:0]   digit_ok,
   output logic                    err,
   output logic                    frame_valid,
   input  logic                    frame_ack
);
   typedef enum logic {COLLECT, READY} state_t;
   state_t state, state_nxt;

   logic                  s1_vld;
   logic [6:0]            s1_seg;
   logic [2:0]            s1_idx;
   logic                  in_range, legal, blank, commit_en;
   logic [3:0]            nib;
   logic [NUM_DIGITS-1:0] commit, done_mask, done_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_seg <= 7'h7F;
         s1_idx <= '0;
      end else begin
         s1_vld <= seg_valid;
         s1_seg <= seg_in;
         s1_idx <= seg_idx;
      end
   end

   assign in_range = (4'(s1_idx) < 4'(NUM_DIGITS));

   generate
      for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
         seg7_digit_track #(.STABLE_COUNT(STABLE_COUNT)) u_trk (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (s1_vld && (s1_idx == 3'(i))),
            .seg    (s1_seg),
            .commit (commit[i])
         );
      end
   endgenerate

   always_comb begin
      legal = 1'b1;
      blank = 1'b0;
      nib   = 4'h0;
      case (s1_seg)
         7'h40: nib = 4'h0;
         7'h79: nib = 4'h1;
         7'h24: nib = 4'h2;
         7'h30: nib = 4'h3;
         7'h19: nib = 4'h4;
         7'h12: nib = 4'h5;
         7'h02: nib = 4'h6;
         7'h78: nib = 4'h7;
         7'h00: nib = 4'h8;
         7'h10: nib = 4'h9;
         7'h08: nib = 4'hA;
         7'h03: nib = 4'hB;
         7'h46: nib = 4'hC;
         7'h21: nib = 4'hD;
         7'h06: nib = 4'hE;
         7'h0E: nib = 4'hF;
         7'h7F: begin legal = 1'b0; blank = 1'b1; end
         default: legal = 1'b0;
      endcase
   end

   // Commits are only honoured while collecting; in READY the frame is frozen.
   assign commit_en   = (state == COLLECT) && (|commit);
   assign done_nxt    = done_mask | commit;
   assign frame_valid = (state == READY);

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (commit_en && (&done_nxt)) state_nxt = READY;
         READY:   if (frame_ack) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hex_out   <= '0;
         digit_ok  <= '0;
         done_mask <= '0;
         err       <= 1'b0;
      end else begin
         err <= (s1_vld && !in_range) || (commit_en && !legal && !blank);
         if (commit_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (commit[i]) begin
                  digit_ok[i] <= legal;
                  if (legal)      hex_out[4*i +: 4] <= nib;
                  else if (blank) hex_out[4*i +: 4] <= 4'h0;
               end
            end
            done_mask <= done_nxt;
         end else if ((state == READY) && frame_ack) begin
            done_mask <= '0;
         end
      end
   end
endmodule

// File: tb/tb_seg7_decode_capture.sv
// Bench for seg7_decode_capture: two instances (8 digits/3 samples, 4 digits/1 sample)
// checked every cycle against a run-length reference model, plus directed checks.
`timescale 1ns/1ps

module tb_seg7_decode_capture;
   logic        clk = 1'b0, rst_n = 1'b0, seg_valid = 1'b0, frame_ack = 1'b0;
   logic [6:0]  seg_in = 7'h7F;
   logic [2:0]  seg_idx = '0;
   logic [31:0] hex8;
   logic [7:0]  ok8;
   logic        err8, fv8;
   logic [15:0] hex4;
   logic [3:0]  ok4;
   logic        err4, fv4;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   seg7_decode_capture #(.NUM_DIGITS(8), .STABLE_COUNT(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .seg_idx(seg_idx), .seg_valid(seg_valid),
      .hex_out(hex8), .digit_ok(ok8), .err(err8), .frame_valid(fv8), .frame_ack(frame_ack));

   seg7_decode_capture #(.NUM_DIGITS(4), .STABLE_COUNT(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .seg_idx(seg_idx), .seg_valid(seg_valid),
      .hex_out(hex4), .digit_ok(ok4), .err(err4), .frame_valid(fv4), .frame_ack(frame_ack));

   logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // reference model: per digit the last pattern seen and the length of its run
   int         nd [2] = '{8, 4};
   int         sc [2] = '{3, 1};
   logic [6:0] m_last [2][8];
   int         m_run  [2][8];
   logic [3:0] m_hex  [2][8];
   bit         m_ok   [2][8];
   bit         m_done [2][8];
   bit         m_rdy  [2];
   bit         m_err  [2];
   bit         m_v;
   logic [6:0] m_s;
   int         m_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int lookup(input logic [6:0] s);
      for (int k = 0; k < 16; k++) if (pat[k] == s) return k;
      return -1;
   endfunction

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         bit rdy0;
         rdy0 = m_rdy[m];
         m_err[m] = 0;
         if (!rst_n) begin
            for (int d = 0; d < 8; d++) begin
               m_last[m][d] = 7'h7F; m_run[m][d] = 0; m_hex[m][d] = 0;
               m_ok[m][d] = 0; m_done[m][d] = 0;
            end
            m_rdy[m] = 0;
         end else begin
            if (m_v && m_i >= nd[m]) m_err[m] = 1;
            else if (m_v) begin
               if (m_s == m_last[m][m_i]) m_run[m][m_i]++;
               else begin m_last[m][m_i] = m_s; m_run[m][m_i] = 1; end
               if (m_run[m][m_i] == sc[m] && !rdy0) begin
                  int code;
                  bit all;
                  code = lookup(m_s);
                  if (code >= 0) begin m_hex[m][m_i] = 4'(code); m_ok[m][m_i] = 1; end
                  else if (m_s == 7'h7F) begin m_hex[m][m_i] = 0; m_ok[m][m_i] = 0; end
                  else begin m_ok[m][m_i] = 0; m_err[m] = 1; end
                  m_done[m][m_i] = 1;
                  all = 1;
                  for (int d = 0; d < nd[m]; d++) all &= m_done[m][d];
                  if (all) m_rdy[m] = 1;
               end
            end
            if (rdy0 && frame_ack) begin
               m_rdy[m] = 0;
               for (int d = 0; d < 8; d++) m_done[m][d] = 0;
            end
         end
      end
      m_v = rst_n && seg_valid;
      m_s = seg_in;
      m_i = int'(seg_idx);
   endtask

   function automatic logic [31:0] exp_hex(input int m);
      logic [31:0] r = '0;
      for (int d = 0; d < nd[m]; d++) r[4*d +: 4] = m_hex[m][d];
      return r;
   endfunction

   function automatic logic [31:0] exp_ok(input int m);
      logic [31:0] r = '0;
      for (int d = 0; d < nd[m]; d++) r[d] = m_ok[m][d];
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("hex8", hex8, exp_hex(0));
      chk("ok8", {24'h0, ok8}, exp_ok(0));
      chk("err8", {31'h0, err8}, {31'h0, m_err[0]});
      chk("fv8", {31'h0, fv8}, {31'h0, m_rdy[0]});
      chk("hex4", {16'h0, hex4}, exp_hex(1));
      chk("ok4", {28'h0, ok4}, exp_ok(1));
      chk("err4", {31'h0, err4}, {31'h0, m_err[1]});
      chk("fv4", {31'h0, fv4}, {31'h0, m_rdy[1]});
   endtask

   task automatic send(input int idx, input logic [6:0] p, input int n);
      for (int k = 0; k < n; k++) begin
         seg_idx = 3'(idx); seg_in = p; seg_valid = 1'b1;
         cyc();
      end
      seg_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      seg_valid = 1'b0;
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic ack();
      frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
   endtask

   function automatic logic [6:0] rndpat();
      int r = $urandom_range(0, 19);
      if (r < 16) return pat[r];
      if (r < 18) return 7'h7F;
      if (r == 18) return 7'h7E;
      return 7'h2A;
   endfunction

   int         v1 [8] = '{1, 2, 3, 4, 10, 11, 12, 13};
   int         ridx;
   logic [6:0] rpat;

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin seg_valid = ~seg_valid; cyc(); end
      chk("rst_hex", hex8, 32'h0);
      chk("rst_ok", {24'h0, ok8}, 32'h0);
      chk("rst_fv", {31'h0, fv8}, 32'h0);
      chk("rst_err", {31'h0, err8}, 32'h0);
      rst_n = 1'b1; seg_valid = 1'b0;
      idle(1);

      send(2, 7'h24, 3); idle(2);
      chk("stab_nib", {28'h0, hex8[11:8]}, 32'h2);
      chk("stab_ok", {31'h0, ok8[2]}, 32'h1);
      send(1, 7'h24, 2); send(1, 7'h30, 1); idle(2);
      chk("short_run", {31'h0, ok8[1]}, 32'h0);

      for (int k = 0; k < 8; k++) send(7 - k, pat[v1[k]], 3);
      idle(2);
      chk("frame1_fv", {31'h0, fv8}, 32'h1);
      chk("frame1_hex", hex8, 32'h1234ABCD);
      for (int k = 0; k < 8; k++) send(k, pat[8], 3);
      idle(2);
      chk("frozen_hex", hex8, 32'h1234ABCD);

      ack();
      chk("ack_fv", {31'h0, fv8}, 32'h0);
      for (int k = 0; k < 8; k++) send(7 - k, pat[k], 3);
      idle(2);
      chk("frame2_hex", hex8, 32'h01234567);
      chk("frame2_fv", {31'h0, fv8}, 32'h1);

      ack();
      for (int k = 0; k < 8; k++) send(k, pat[15], 3);
      frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
      cyc();
      chk("ack_coinc_fv", {31'h0, fv8}, 32'h1);
      chk("ack_coinc_hex", hex8, 32'hFFFFFFFF);

      ack();
      send(0, 7'h7E, 3); idle(2);
      chk("illegal_ok", {31'h0, ok8[0]}, 32'h0);
      chk("illegal_nib", {28'h0, hex8[3:0]}, 32'hF);
      send(5, pat[3], 1); cyc();
      chk("idx_range_err4", {31'h0, err4}, 32'h1);
      chk("idx_range_ok4", {28'h0, ok4}, {28'h0, exp_ok(1)});
      send(1, 7'h7F, 3); idle(2);
      chk("blank_ok", {31'h0, ok8[1]}, 32'h0);
      chk("blank_nib", {28'h0, hex8[7:4]}, 32'h0);

      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      for (int k = 0; k < 6; k++) send(k, pat[9], 3);
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      send(6, pat[9], 3); send(7, pat[9], 3); idle(2);
      chk("midrst_fv", {31'h0, fv8}, 32'h0);
      for (int k = 0; k < 6; k++) send(k, pat[14], 3);
      idle(2);
      chk("midrst_refill_fv", {31'h0, fv8}, 32'h1);

      ridx = 0; rpat = pat[0];
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) begin ridx = $urandom_range(0, 7); rpat = rndpat(); end
         seg_idx   = 3'(ridx);
         seg_in    = rpat;
         seg_valid = ($urandom_range(0, 4) != 0);
         frame_ack = ($urandom_range(0, 9) == 0);
         rst_n     = ($urandom_range(0, 199) != 0);
         cyc();
      end
      rst_n = 1'b1; frame_ack = 1'b0;
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
